// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the current PC, fetches the instruction at that PC, presents it until
// the pipeline accepts it, then selects the next PC (jump > branch > PC+4).
// A misaligned next PC parks the block in a sticky trap state until reset.
module pc_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_out,
  input  logic             branch_take,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             stall,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic             fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] instr_reg, instr_next;
  logic [WIDTH-1:0] target;

  // Next-PC candidate: jump beats branch, branch beats the sequential PC
  always_comb begin
    target = pc_plus4;
    if (jump)
      target = jump_target;
    else if (branch_take)
      target = branch_target;
  end

  // Next-state and datapath load decisions
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        // Unbounded wait states: stay here until memory acknowledges
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // Redirect inputs only matter on the cycle the instruction is accepted
        if (!stall) begin
          if (target[1:0] == 2'b00) begin
            pc_next    = target;
            state_next = FETCH;
          end else begin
            // Keep the PC of the instruction that produced the bad target
            state_next = FAULT;
          end
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, PC and instruction registers; reset abandons any fetch or stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
    end
  end

  // Control outputs decode the state register only, so no input reaches them
  assign imem_req    = (state_reg == FETCH);
  assign instr_valid = (state_reg == ISSUE);
  assign fault       = (state_reg == FAULT);
  assign pc_out      = pc_reg;
  assign instr       = instr_reg;

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pc_fetch;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pc_plus4, pc_out, branch_target, jump_target, imem_rdata, instr;
  logic         branch_take, jump, stall, imem_req, imem_ack, instr_valid, fault;

  int passed = 0;
  int total  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  // The external PC+4 adder
  assign pc_plus4 = pc_out + 32'd4;

  pc_fetch #(.WIDTH(W), .RESET_PC(32'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_plus4     (pc_plus4),
    .pc_out       (pc_out),
    .branch_take  (branch_take),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .fault        (fault)
  );

  // Behavioural model: "started" = first cycle after reset has passed,
  // "have" = an accepted instruction is being presented, "trapped" = sticky fault.
  logic [W-1:0] m_pc, m_instr;
  bit           m_started, m_have, m_trapped;

  function automatic logic [W-1:0] model_next();
    if (jump) return jump_target;
    if (branch_take) return branch_target;
    return m_pc + 32'd4;
  endfunction

  // Model update on each clock edge (or reset)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'd0; m_instr <= 32'd0;
      m_started <= 1'b0; m_have <= 1'b0; m_trapped <= 1'b0;
    end else if (m_trapped) begin
      m_trapped <= 1'b1;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (!m_have) begin
      if (imem_ack) begin
        m_instr <= imem_rdata;
        m_have  <= 1'b1;
      end
    end else if (!stall) begin
      if (model_next() % 4 == 0) begin
        m_pc   <= model_next();
        m_have <= 1'b0;
      end else begin
        m_trapped <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare DUT against the model away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      check("m.pc_out", pc_out, m_pc);
      check("m.imem_req", {31'b0, imem_req}, {31'b0, m_started && !m_have && !m_trapped});
      check("m.instr_valid", {31'b0, instr_valid}, {31'b0, m_have && !m_trapped});
      check("m.instr", instr, m_instr);
      check("m.fault", {31'b0, fault}, {31'b0, m_trapped});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string name, input logic [W-1:0] pc, input logic req,
                         input logic vld, input logic flt);
    check({name, ".pc"}, pc_out, pc);
    check({name, ".req"}, {31'b0, imem_req}, {31'b0, req});
    check({name, ".valid"}, {31'b0, instr_valid}, {31'b0, vld});
    check({name, ".fault"}, {31'b0, fault}, {31'b0, flt});
  endtask

  initial begin
    imem_ack = 1'b1; imem_rdata = 32'h11111111; stall = 1'b0;
    branch_take = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_ctl("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset.instr", instr, 32'h0);
    rst = 1'b0;
    check_en = 1'b1;

    // Sequential fetch with zero-wait memory
    step(); chk_ctl("seq.fetch0", 32'h0, 1'b1, 1'b0, 1'b0);
    step(); chk_ctl("seq.issue0", 32'h0, 1'b0, 1'b1, 1'b0);
    check("seq.instr0", instr, 32'h11111111);
    step(); chk_ctl("seq.fetch4", 32'h4, 1'b1, 1'b0, 1'b0);
    step(); chk_ctl("seq.issue4", 32'h4, 1'b0, 1'b1, 1'b0);
    step(); chk_ctl("seq.fetch8", 32'h8, 1'b1, 1'b0, 1'b0);
    step(); chk_ctl("seq.issue8", 32'h8, 1'b0, 1'b1, 1'b0);

    // Stall holds the instruction and ignores the branch
    stall = 1'b1; branch_take = 1'b1; branch_target = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step(); chk_ctl("stall.hold", 32'h8, 1'b0, 1'b1, 1'b0);
      check("stall.instr", instr, 32'h11111111);
    end
    stall = 1'b0;
    step(); chk_ctl("stall.branch", 32'h40, 1'b1, 1'b0, 1'b0);
    branch_take = 1'b0;
    step(); chk_ctl("br.issue40", 32'h40, 1'b0, 1'b1, 1'b0);

    // Jump has priority over branch
    jump = 1'b1; jump_target = 32'h100; branch_take = 1'b1; branch_target = 32'h40;
    step(); chk_ctl("jump.prio", 32'h100, 1'b1, 1'b0, 1'b0);
    jump = 1'b0; branch_take = 1'b0;

    // Memory wait states: four cycles without ack, then ack on the fifth
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_ctl("wait.fetch", 32'h100, 1'b1, 1'b0, 1'b0);
      imem_rdata = $urandom;
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    chk_ctl("wait.ack", 32'h100, 1'b1, 1'b0, 1'b0);
    step(); chk_ctl("wait.issue", 32'h100, 1'b0, 1'b1, 1'b0);
    check("wait.instr", instr, 32'hDEADBEEF);

    // Misaligned branch target traps and sticks until reset
    rst = 1'b1; #2; rst = 1'b0;
    imem_rdata = 32'h22222222;
    repeat (4) step();
    chk_ctl("trap.pre", 32'h4, 1'b0, 1'b1, 1'b0);
    branch_take = 1'b1; branch_target = 32'h42;
    step(); chk_ctl("trap.hit", 32'h4, 1'b0, 1'b0, 1'b1);
    branch_take = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_ctl("trap.stick", 32'h4, 1'b0, 1'b0, 1'b1);
    end
    rst = 1'b1; #1;
    chk_ctl("trap.rst", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Asynchronous reset in the middle of a fetch
    step(); step(); step();
    chk_ctl("async.pre", 32'h4, 1'b1, 1'b0, 1'b0);
    #2; rst = 1'b1; #1;
    chk_ctl("async.rst", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_ctl("async.resume", 32'h0, 1'b1, 1'b0, 1'b0);
    step();

    // Wrap-around of the sequential PC
    jump = 1'b1; jump_target = 32'hFFFFFFFC;
    step(); chk_ctl("wrap.jump", 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0);
    jump = 1'b0;
    step(); chk_ctl("wrap.issue", 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0);
    step(); chk_ctl("wrap.zero", 32'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      imem_ack    = ($urandom_range(0, 3) != 0);
      imem_rdata  = $urandom;
      stall       = ($urandom_range(0, 3) == 0);
      jump        = ($urandom_range(0, 7) == 0);
      branch_take = ($urandom_range(0, 3) == 0);
      jump_target   = ($urandom_range(0, 60) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      branch_target = ($urandom_range(0, 60) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      if (m_trapped ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0)) begin
        rst = 1'b1; #2; rst = 1'b0;
      end
      step();
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program-counter register and instruction-fetch sequencer for the basic CPU.
- Drives the current PC into the PC+4 adder and the instruction memory, and takes the adder's result back as the sequential next PC.
- Selects the next PC from sequential, branch or jump sources, handshakes with instruction memory, holds the fetched instruction under stall, and traps misaligned targets.

Parameters:
- WIDTH, 32, width of PC, targets and instruction word.
- RESET_PC, 32'd0, PC value loaded on reset; must be word-aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_plus4  input  WIDTH  sequential next PC, produced by the PC+4 adder from pc_out.
- pc_out  output  WIDTH  current PC; feeds the adder input and the instruction-memory address.
- branch_take  input  1  taken-branch request; sampled only in ISSUE with stall=0.
- branch_target  input  WIDTH  branch destination.
- jump  input  1  jump request; sampled only in ISSUE with stall=0.
- jump_target  input  WIDTH  jump destination.
- stall  input  1  downstream not ready; holds the current instruction.
- imem_req  output  1  fetch request to instruction memory at address pc_out.
- imem_ack  input  1  memory accepts the request and returns data this cycle.
- imem_rdata  input  WIDTH  instruction word; valid when imem_ack=1.
- instr  output  WIDTH  latched instruction.
- instr_valid  output  1  instr holds the instruction at pc_out.
- fault  output  1  sticky misaligned-target trap.

Behaviour:
- Reset (async, immediate on rst=1): pc_out=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0, state=IDLE. Reset mid-fetch or mid-stall abandons everything; there is no pending state afterwards.
- States: IDLE, FETCH, ISSUE, FAULT. The state is registered; imem_req and instr_valid are decoded from the state register only (no input-to-output combinational path).
- IDLE:
  - Outputs: imem_req=0, instr_valid=0.
  - Transition: unconditionally to FETCH on the next edge. First request is therefore the first cycle after reset release.
- FETCH:
  - Outputs: imem_req=1, instr_valid=0, pc_out stable.
  - imem_ack=1 at an edge: instr<=imem_rdata, go to ISSUE.
  - imem_ack=0: remain in FETCH. Wait states are unbounded.
  - Minimum fetch latency with zero-wait memory: 1 cycle in FETCH.
- ISSUE:
  - Outputs: imem_req=0, instr_valid=1.
  - stall=1: hold state, pc_out and instr unchanged. Branch/jump inputs are ignored.
  - stall=0: compute next PC. Priority: jump, then branch_take, then pc_plus4.
    - next[1:0]==2'b00: pc_out<=next, go to FETCH. instr_valid drops for at least one cycle, so each instruction is issued exactly once.
    - next[1:0]!=2'b00: pc_out unchanged, fault<=1, go to FAULT.
- FAULT:
  - Outputs: imem_req=0, instr_valid=0, fault=1.
  - Absorbing state; exited only by rst.
- imem_ack outside FETCH is ignored; instr does not change.
- Arithmetic/width: the block performs no addition itself; it relies on pc_plus4 = pc_out + 4 from the adder. Wrap-around is legal: pc_out=32'hFFFFFFFC with pc_plus4=32'h0 loads 0 with no fault.
- Targets are taken verbatim (absolute), with no sign extension or offset arithmetic inside the block.
- Throughput with zero-wait memory and no stall: one instruction every 2 cycles.

Test Plan:
- Reset release, imem_ack tied 1, rdata=32'h11111111, stall=0 → imem_req high in the 1st cycle after release with pc_out=0; instr_valid=1 next cycle with instr=32'h11111111; pc_out then advances 0, 4, 8, 12 every 2 cycles.
- In ISSUE at pc=8 assert stall for 3 cycles with branch_take=1, branch_target=32'h40 → pc_out stays 8 and instr is held for 3 cycles; after stall drops, a branch still high is taken and pc_out=32'h40.
- jump=1, jump_target=32'h100 and branch_take=1, branch_target=32'h40 in the same ISSUE cycle → pc_out=32'h100 (jump wins).
- imem_ack held 0 for 4 cycles in FETCH, random rdata, then ack with 32'hDEADBEEF → imem_req high for 5 cycles, instr_valid low throughout, instr=32'hDEADBEEF afterwards; pc_out unchanged.
- branch_target=32'h42 taken at pc=4 → fault=1 next edge, pc_out stays 4, imem_req and instr_valid stay 0 indefinitely; rst clears fault and restores pc_out=0.
- rst asserted mid-FETCH, asynchronously between edges → pc_out=0, imem_req=0, instr_valid=0 immediately without a clock edge; normal fetch resumes after release. Separately, a sequential step at pc=32'hFFFFFFFC → pc_out=0, fault=0.
